fft_bitrev_reorder: RTL and testbench

Output reorder stage placed directly downstream of the 256-point parallel DIF FFT (`FFT_20150605`). The FFT emits bins in bit-reversed order on its 20-bit `Y_Re_FIFO_Out` / `Y_Im_FIFO_Out` streams. This block captures each 256-bin frame into a ping-pong buffer and replays it in natural order (bin 0..255) with a valid/ready handshake. Frames are sent onward to the magnitude/logging stage.

---
 rtl/fft_pkg.sv | 40 ++++
 rtl/fft_pingpong_ram.sv | 48 ++++
 rtl/fft_bitrev_reorder.sv | 247 ++++++++++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
//   Shared constants and helpers for the 256-point FFT datapath and its
//   output reorder stage.
//
//   DataWidth : FFT input sample width
//   LOG2N     : log2 of the frame length
//   N         : frame length (number of bins)
//   BinWidth  : width of one real or imaginary output bin (DataWidth+8)
//   WordWidth : width of one stored bin (real and imaginary packed)
//   bitrev()  : LOG2N-bit index bit reversal. The FFT bench checker uses it too.
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int DataWidth = 12;
    localparam int LOG2N     = 8;
    localparam int N         = 1 << LOG2N;
    localparam int BinWidth  = DataWidth + 8;
    localparam int WordWidth = 2 * BinWidth;

    // Index of the last bin of a frame and the one before it.
    localparam logic [LOG2N-1:0] LastIdx   = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] PenultIdx = LOG2N'(N - 2);

    // Read-side sequencer states.
    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_FETCH  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] result;
        for (int i = 0; i < LOG2N; i++) begin
            result[i] = idx[LOG2N-1-i];
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// -----------------------------------------------------------------------------
// fft_pingpong_ram
//   Simple dual-port memory that holds two frames (banks) of packed bins.
//   It has one write port and one synchronous read port with 1-cycle latency.
//   The address is {bank, LOG2N-bit index}. The memory contents have no reset.
//   The read data register clears on reset and holds its value whenever
//   rd_en is low. The reorder stage uses this register directly as its output
//   holding register.
//
//   clk     : clock, rising edge
//   rst     : synchronous active-low reset (read data register only)
//   wr_en   : write strobe
//   wr_addr : {bank, index} write address
//   wr_data : packed {re, im} bin
//   rd_en   : load rd_data from rd_addr at the next edge
//   rd_addr : {bank, index} read address
//   rd_data : registered read data
// -----------------------------------------------------------------------------
module fft_pingpong_ram
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [LOG2N:0]       wr_addr,
    input  logic [WordWidth-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [LOG2N:0]       rd_addr,
    output logic [WordWidth-1:0] rd_data
);

    logic [WordWidth-1:0] mem [0:2*N-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
//   Captures 256-bin FFT frames that arrive in bit-reversed order into a
//   ping-pong buffer. It replays each frame in natural order (bin 0..255) on a
//   valid/ready output stream.
//
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   in_valid   : input bin present this cycle
//   in_sof     : first bin of a frame (bit-reversed index 0); restarts the
//                write counter
//   in_re/im   : signed input bin, bit-reversed order
//   out_ready  : downstream accepts the current output
//   out_valid  : out_re/out_im/out_index/out_sof/out_eof are valid
//   out_re/im  : signed output bin, natural order
//   out_index  : natural bin number of the current output
//   out_sof    : current output is bin 0
//   out_eof    : current output is bin 255
//   overflow   : sticky; a whole frame was dropped because no bank was free
//
//   Output handshake: a transfer happens on every rising edge where out_valid
//   and out_ready are both high. Once out_valid rises, out_valid and every
//   output field stay unchanged until that transfer happens.
//
//   Bank release: the RAM word for bin 255 is read into the output register
//   when bin 254 is accepted. From that point the bank's RAM contents are no
//   longer needed. The full flag clears at that same edge, and the write side
//   treats the bank as free in that same cycle. As a result, a continuous
//   input stream can start its next frame in the bank that is just being
//   drained, without a dropped frame and without an output bubble.
// -----------------------------------------------------------------------------
module fft_bitrev_reorder
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic [BinWidth-1:0] in_re,
    input  logic [BinWidth-1:0] in_im,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [BinWidth-1:0] out_re,
    output logic [BinWidth-1:0] out_im,
    output logic [LOG2N-1:0]    out_index,
    output logic                out_sof,
    output logic                out_eof,
    output logic                overflow
);

    // ---------------------------------------------------------------------
    // Shared bank bookkeeping
    // ---------------------------------------------------------------------
    logic [1:0] full;
    logic [1:0] full_next;

    // ---------------------------------------------------------------------
    // Write side
    // ---------------------------------------------------------------------
    logic [LOG2N-1:0] wcnt;
    logic [LOG2N-1:0] wcnt_eff;
    logic             wbank;
    logic             dropping;
    logic             frame_start;
    logic             bank_busy;
    logic             drop_now;
    logic             wr_en;
    logic             wr_last;
    logic [LOG2N:0]   wr_addr;

    // ---------------------------------------------------------------------
    // Read side
    // ---------------------------------------------------------------------
    rd_state_t        rd_state;
    rd_state_t        rd_state_next;
    logic             rbank;
    logic             rbank_next;
    logic [LOG2N-1:0] rcnt;
    logic [LOG2N-1:0] rcnt_next;
    logic [LOG2N-1:0] rcnt_inc;
    logic             rd_en;
    logic [LOG2N:0]   rd_addr;
    logic             rd_release;
    logic [WordWidth-1:0] rd_data;

    // ---------------------------------------------------------------------
    // Write-side combinational decode
    // ---------------------------------------------------------------------
    always_comb begin
        // An in_sof restarts the frame at this very sample, so any partial
        // frame in the write bank is overwritten and that bank stays not-full.
        wcnt_eff    = in_sof ? '0 : wcnt;
        frame_start = (wcnt_eff == '0);
        // The bank being released this cycle is already free to accept a
        // new frame.
        bank_busy   = full[wbank] && !(rd_release && (rbank == wbank));
        // The drop decision is made once per frame, at its first sample.
        drop_now    = frame_start ? bank_busy : dropping;
        wr_en       = in_valid && !drop_now;
        wr_last     = wr_en && (wcnt_eff == LastIdx);
        wr_addr     = {wbank, bitrev(wcnt_eff)};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt     <= '0;
            wbank    <= 1'b0;
            dropping <= 1'b0;
            overflow <= 1'b0;
        end else if (in_valid) begin
            // The counter advances through dropped frames too, so alignment
            // with the FFT frame boundaries is kept.
            wcnt     <= wcnt_eff + 1'b1;
            dropping <= drop_now;
            if (frame_start && bank_busy) begin
                overflow <= 1'b1;
            end
            if (wr_last) begin
                wbank <= ~wbank;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Full flags: set by a completed write, cleared by the read-side release.
    // A set and a clear never hit the same bank in the same cycle. A bank is
    // only written while it is not full, and filling it takes a full frame.
    // ---------------------------------------------------------------------
    always_comb begin
        full_next = full;
        if (rd_release) begin
            full_next[rbank] = 1'b0;
        end
        if (wr_last) begin
            full_next[wbank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full <= 2'b00;
        end else begin
            full <= full_next;
        end
    end

    // ---------------------------------------------------------------------
    // Read sequencer
    //   rbank always points at the oldest full bank. Banks are completed
    //   alternately and drained alternately, so a single toggle tracks it.
    //   rcnt is the natural index of the word held in the output register.
    // ---------------------------------------------------------------------
    assign rcnt_inc = rcnt + 1'b1;

    always_comb begin
        rd_state_next = rd_state;
        rbank_next    = rbank;
        rcnt_next     = rcnt;
        rd_en         = 1'b0;
        rd_addr       = {rbank, rcnt_inc};
        rd_release    = 1'b0;

        case (rd_state)
            RD_IDLE: begin
                if (full[rbank]) begin
                    rd_state_next = RD_FETCH;
                end
            end

            RD_FETCH: begin
                rd_en         = 1'b1;
                rd_addr       = {rbank, {LOG2N{1'b0}}};
                rcnt_next     = '0;
                rd_state_next = RD_STREAM;
            end

            RD_STREAM: begin
                if (out_ready) begin
                    if (rcnt == LastIdx) begin
                        // rbank has already moved to the other bank here.
                        if (full[rbank]) begin
                            rd_en     = 1'b1;
                            rd_addr   = {rbank, {LOG2N{1'b0}}};
                            rcnt_next = '0;
                        end else begin
                            rcnt_next     = '0;
                            rd_state_next = RD_IDLE;
                        end
                    end else begin
                        rd_en     = 1'b1;
                        rd_addr   = {rbank, rcnt_inc};
                        rcnt_next = rcnt_inc;
                        // Final RAM read of this bank: hand it back to the
                        // write side.
                        if (rcnt == PenultIdx) begin
                            rd_release = 1'b1;
                            rbank_next = ~rbank;
                        end
                    end
                end
            end

            default: begin
                rd_state_next = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state <= RD_IDLE;
            rbank    <= 1'b0;
            rcnt     <= '0;
        end else begin
            rd_state <= rd_state_next;
            rbank    <= rbank_next;
            rcnt     <= rcnt_next;
        end
    end

    // ---------------------------------------------------------------------
    // Storage. The RAM read register is the output holding register. It
    // changes only on rd_en, and rd_en is only raised on a transfer or in
    // FETCH (while out_valid is low).
    // ---------------------------------------------------------------------
    fft_pingpong_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({in_re, in_im}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign out_valid = (rd_state == RD_STREAM);
    assign out_re    = rd_data[WordWidth-1:BinWidth];
    assign out_im    = rd_data[BinWidth-1:0];
    assign out_index = rcnt;
    assign out_sof   = out_valid && (rcnt == '0);
    assign out_eof   = out_valid && (rcnt == LastIdx);

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev_reorder
//   Directed bench for fft_bitrev_reorder. The expected stream for each frame
//   is the natural-order rearrangement of the bins sent for that frame. Each
//   test states which of its frames must survive. A single monitor compares
//   every output transfer against the expected queue and checks that stalled
//   outputs hold.
// -----------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

  localparam int BW = 20;
  localparam int LG = 8;
  localparam int NB = 256;
  localparam int W  = 2 * BW + LG;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [BW-1:0] in_re = '0;
  logic [BW-1:0] in_im = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [BW-1:0] out_re;
  logic [BW-1:0] out_im;
  logic [LG-1:0] out_index;
  logic          out_sof;
  logic          out_eof;
  logic          overflow;

  fft_bitrev_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_index (out_index),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .overflow  (overflow)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_accepted = 0;
  int first_valid_cyc = -1;
  int last_valid_cyc = -1;
  int valid_count = 0;
  logic [BW-1:0] got_re [NB];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference for the bit-reversed write order.
  function automatic int br(input int k);
    int r = 0;
    for (int i = 0; i < LG; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  function automatic logic [W-1:0] bin_word(input int base, input int n);
    return {BW'(base + n), BW'(-(base + n + 1)), LG'(n)};
  endfunction

  // Monitor: sample away from the active edge.
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_word;
  initial begin
    logic [W-1:0] w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", {63'd0, out_valid}, 64'd1);
          check("hold_data", {16'd0, out_re, out_im, out_index}, {16'd0, hold_word});
        end
        hold_pend = 1'b0;
        if (out_valid) begin
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          last_valid_cyc = cyc;
          valid_count++;
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              check("spurious_valid", {63'd0, out_valid}, 64'd0);
            end else begin
              w = exp_q.pop_front();
              check("data", {16'd0, out_re, out_im, out_index}, {16'd0, w});
              check("sof", {63'd0, out_sof}, {63'd0, (w[LG-1:0] == 0)});
              check("eof", {63'd0, out_eof}, {63'd0, (w[LG-1:0] == NB - 1)});
              got_re[out_index] = out_re;
              n_accepted++;
            end
          end else begin
            hold_pend = 1'b1;
            hold_word = {out_re, out_im, out_index};
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // Sends write-order samples k_from..k_to of a frame. Sample k carries
  // natural bin br(k). When keep is set, the full frame is expected downstream.
  task automatic send(input int base, input int k_from, input int k_to, input bit keep);
    if (keep) for (int n = 0; n < NB; n++) exp_q.push_back(bin_word(base, n));
    for (int k = k_from; k <= k_to; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_sof   = (k == k_from);
      in_re    = BW'(base + br(k));
      in_im    = BW'(-(base + br(k) + 1));
    end
  endtask

  // Ends the input burst; t is the edge that captured the last sample.
  task automatic idle(output int t);
    @(posedge clk); #1;
    t = cyc;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic check_zero(input string name);
    @(negedge clk);
    check({name, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({name, "_re"}, {44'd0, out_re}, 64'd0);
    check({name, "_im"}, {44'd0, out_im}, 64'd0);
    check({name, "_index"}, {56'd0, out_index}, 64'd0);
    check({name, "_sof"}, {63'd0, out_sof}, 64'd0);
    check({name, "_eof"}, {63'd0, out_eof}, 64'd0);
    check({name, "_overflow"}, {63'd0, overflow}, 64'd0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({name, "_idle_after"}, {63'd0, out_valid}, 64'd0);
  endtask

  // ---------------------------------------------------------------- tests
  initial begin
    int t;
    int target;

    // Pin the reference reorder function with hand-computed values.
    check("br_1", 64'(br(1)), 64'd128);
    check("br_3", 64'(br(3)), 64'd192);
    check("br_100", 64'(br(100)), 64'd38);

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check_zero("reset");

    // Single frame: bin k written at position k gives out_re = 0..255.
    out_ready = 1'b1;
    first_valid_cyc = -1;
    send(0, 0, NB - 1, 1'b1);
    idle(t);
    drain("single");
    check("single_latency", 64'(first_valid_cyc), 64'(t + 2));
    check("single_re0", {44'd0, got_re[0]}, 64'd0);
    check("single_re128", {44'd0, got_re[128]}, 64'd128);
    check("single_re255", {44'd0, got_re[255]}, 64'd255);

    // Three back-to-back frames: 768 contiguous outputs, no overflow.
    first_valid_cyc = -1;
    valid_count = 0;
    send(1000, 0, NB - 1, 1'b1);
    send(2000, 0, NB - 1, 1'b1);
    send(3000, 0, NB - 1, 1'b1);
    idle(t);
    drain("b2b");
    check("b2b_count", 64'(valid_count), 64'd768);
    check("b2b_span", 64'(last_valid_cyc - first_valid_cyc + 1), 64'd768);
    check("b2b_overflow", {63'd0, overflow}, 64'd0);

    // Resync at wcnt=100: the partial frame is discarded.
    send(5000, 0, 99, 1'b0);
    send(7000, 0, NB - 1, 1'b1);
    idle(t);
    drain("resync100");

    // in_sof where wcnt==255 was expected: still a resync, no frame emitted.
    send(8000, 0, NB - 2, 1'b0);
    send(9000, 0, NB - 1, 1'b1);
    idle(t);
    drain("resync255");
    check("resync_overflow", {63'd0, overflow}, 64'd0);

    // Random 50% back-pressure on two frames.
    fork
      begin
        send(11000, 0, NB - 1, 1'b1);
        send(12000, 0, NB - 1, 1'b1);
        idle(t);
      end
      begin
        for (int i = 0; i < 1400; i++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain("random");
    check("random_overflow", {63'd0, overflow}, 64'd0);

    // Stall for 600 cycles while three frames arrive: the third is dropped.
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        send(20000, 0, NB - 1, 1'b1);
        send(30000, 0, NB - 1, 1'b1);
        send(40000, 0, NB - 1, 1'b0);
        idle(t);
      end
      begin
        repeat (600) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stall");
    check("stall_overflow", {63'd0, overflow}, 64'd1);

    // Reset in the middle of streaming a frame.
    send(50000, 0, NB - 1, 1'b1);
    idle(t);
    target = n_accepted + 50;
    for (int i = 0; i < 1000 && n_accepted < target; i++) @(posedge clk);
    check("midreset_reached", {63'd0, (n_accepted >= target)}, 64'd1);
    do_reset();
    check_zero("midreset");
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("midreset_no_stale", {63'd0, out_valid}, 64'd0);

    // The next complete frame after reset.
    send(60000, 0, NB - 1, 1'b1);
    idle(t);
    drain("postreset");
    check("postreset_overflow", {63'd0, overflow}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog: never hang.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
